// File: rtl/tpu_tiled_array.sv
// tpu_tiled_array: tiled output-stationary systolic matmul C = A x B over a ROWS x COLS PE grid
module tpu_tiled_array #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int DIM_W  = 8,
  parameter int IDX_W  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DIM_W-1:0]       K,
  input  logic [DIM_W-1:0]       M,
  input  logic [DIM_W-1:0]       N,
  output logic                   busy,
  output logic                   done,
  output logic                   A_wr_en,
  output logic [IDX_W-1:0]       A_index,
  output logic [ROWS*DATA_W-1:0] A_data_in,
  input  logic [ROWS*DATA_W-1:0] A_data_out,
  output logic                   B_wr_en,
  output logic [IDX_W-1:0]       B_index,
  output logic [COLS*DATA_W-1:0] B_data_in,
  input  logic [COLS*DATA_W-1:0] B_data_out,
  output logic                   C_wr_en,
  output logic [IDX_W-1:0]       C_index,
  output logic [COLS*ACC_W-1:0]  C_data_in
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WRITE, DONE} state_t;
  state_t state;
  logic [DIM_W-1:0] k_q, m_q, mt, nt;
  logic [DIM_W:0] mt_n, nt_n, mt_c, nt_c;
  logic [IDX_W-1:0] cnt, a_base, b_base, row_abs;
  logic [RW-1:0] wrow;
  logic fv_q, last, emit, clr;
  logic [DATA_W-1:0] a_in [ROWS];
  logic [DATA_W-1:0] b_in [COLS];
  logic [DATA_W-1:0] a_edge [ROWS];
  logic [DATA_W-1:0] b_edge [COLS];
  logic [DATA_W-1:0] a_sr [ROWS][ROWS];
  logic [DATA_W-1:0] b_sr [COLS][COLS];
  logic [DATA_W-1:0] a_p [ROWS][COLS];
  logic [DATA_W-1:0] b_p [ROWS][COLS];
  logic [DATA_W-1:0] a_x [ROWS][COLS];
  logic [DATA_W-1:0] b_x [ROWS][COLS];
  logic [ACC_W-1:0] acc [ROWS][COLS];
  logic [COLS*ACC_W-1:0] row_data;

  assign A_wr_en   = 1'b0;
  assign A_data_in = '0;
  assign B_wr_en   = 1'b0;
  assign B_data_in = '0;

  function automatic logic [ACC_W-1:0] prod(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ps;
    logic [2*DATA_W-1:0] pu;
    ps = $signed(a) * $signed(b);
    pu = a * b;
    if (SIGNED) return ACC_W'(ps);
    return ACC_W'(pu);
  endfunction

  // tile counts, phase decode, operand gating/skew taps and selected write-back row
  always_comb begin
    mt_c = ({1'b0, M} + (DIM_W+1)'(ROWS-1)) / (DIM_W+1)'(ROWS);
    nt_c = ({1'b0, N} + (DIM_W+1)'(COLS-1)) / (DIM_W+1)'(COLS);
    clr = state == CLEAR;
    last = cnt == IDX_W'(k_q) + IDX_W'(ROWS+COLS-2);
    emit = (state == FEED && last) || (state == WRITE && cnt != IDX_W'(ROWS-1));
    wrow = state == WRITE ? RW'(cnt + 1'b1) : '0;
    row_abs = IDX_W'(mt) * IDX_W'(ROWS) + IDX_W'(wrow);
    for (int r = 0; r < ROWS; r++) a_in[r] = fv_q ? A_data_out[(ROWS-1-r)*DATA_W +: DATA_W] : '0;
    for (int c = 0; c < COLS; c++) b_in[c] = fv_q ? B_data_out[(COLS-1-c)*DATA_W +: DATA_W] : '0;
    a_edge[0] = a_in[0];
    for (int r = 1; r < ROWS; r++) a_edge[r] = a_sr[r][r-1];
    b_edge[0] = b_in[0];
    for (int c = 1; c < COLS; c++) b_edge[c] = b_sr[c][c-1];
    for (int r = 0; r < ROWS; r++) begin
      a_x[r][0] = a_edge[r];
      for (int c = 1; c < COLS; c++) a_x[r][c] = a_p[r][c-1];
    end
    for (int c = 0; c < COLS; c++) begin
      b_x[0][c] = b_edge[c];
      for (int r = 1; r < ROWS; r++) b_x[r][c] = b_p[r-1][c];
    end
    row_data = '0;
    for (int c = 0; c < COLS; c++) row_data[(COLS-1-c)*ACC_W +: ACC_W] = acc[wrow][c];
  end

  // job sequencer: tile loop, buffer addressing and registered result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      C_wr_en <= 1'b0;
      A_index <= '0;
      B_index <= '0;
      C_index <= '0;
      C_data_in <= '0;
      k_q <= '0;
      m_q <= '0;
      mt <= '0;
      nt <= '0;
      mt_n <= '0;
      nt_n <= '0;
      cnt <= '0;
      a_base <= '0;
      b_base <= '0;
    end else begin
      done <= 1'b0;
      C_wr_en <= 1'b0;
      if (emit) begin
        C_wr_en <= row_abs < IDX_W'(m_q);
        C_index <= row_abs * IDX_W'(nt_n) + IDX_W'(nt);
        C_data_in <= row_data;
      end
      case (state)
        IDLE: if (in_valid) begin
          k_q <= K;
          m_q <= M;
          mt_n <= mt_c;
          nt_n <= nt_c;
          mt <= '0;
          nt <= '0;
          a_base <= '0;
          b_base <= '0;
          busy <= 1'b1;
          if (K == '0 || M == '0 || N == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else state <= CLEAR;
        end
        CLEAR: begin
          cnt <= '0;
          A_index <= a_base;
          B_index <= b_base;
          state <= FEED;
        end
        FEED: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (cnt + 1'b1 < IDX_W'(k_q)) begin
            A_index <= a_base + cnt + 1'b1;
            B_index <= b_base + cnt + 1'b1;
          end
          if (last) state <= WRITE;
        end
        WRITE: if (cnt == IDX_W'(ROWS-1)) begin
          if ({1'b0, nt} + 1'b1 == nt_n) begin
            nt <= '0;
            b_base <= '0;
            if ({1'b0, mt} + 1'b1 == mt_n) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              mt <= mt + 1'b1;
              a_base <= a_base + IDX_W'(k_q);
              state <= CLEAR;
            end
          end else begin
            nt <= nt + 1'b1;
            b_base <= b_base + IDX_W'(k_q);
            state <= CLEAR;
          end
        end else cnt <= cnt + 1'b1;
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // systolic datapath: edge skew lines, PE pass-through registers and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) for (int i = 0; i < ROWS; i++) a_sr[r][i] <= '0;
      for (int c = 0; c < COLS; c++) for (int i = 0; i < COLS; i++) b_sr[c][i] <= '0;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
        a_p[r][c] <= '0;
        b_p[r][c] <= '0;
        acc[r][c] <= '0;
      end
    end else begin
      fv_q <= state == FEED && cnt < IDX_W'(k_q);
      for (int r = 0; r < ROWS; r++) begin
        a_sr[r][0] <= clr ? '0 : a_in[r];
        for (int i = 1; i < ROWS; i++) a_sr[r][i] <= clr ? '0 : a_sr[r][i-1];
      end
      for (int c = 0; c < COLS; c++) begin
        b_sr[c][0] <= clr ? '0 : b_in[c];
        for (int i = 1; i < COLS; i++) b_sr[c][i] <= clr ? '0 : b_sr[c][i-1];
      end
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
        a_p[r][c] <= clr ? '0 : a_x[r][c];
        b_p[r][c] <= clr ? '0 : b_x[r][c];
        acc[r][c] <= clr ? '0 : state == FEED ? acc[r][c] + prod(a_x[r][c], b_x[r][c]) : acc[r][c];
      end
    end
  end
endmodule

// File: tb/tb_tpu_tiled_array.sv
// tb_tpu_tiled_array: directed checks of the tiled systolic matmul (unsigned 32-bit and signed 16-bit builds)
module tb_tpu_tiled_array;
  logic clk = 1'b0, rst_n = 1'b0, iv0 = 1'b0, iv1 = 1'b0, clr = 1'b0;
  logic [7:0] K = '0, M = '0, N = '0;
  logic busy0, done0, awe0, bwe0, cwe0, busy1, done1, awe1, bwe1, cwe1;
  logic [15:0] ai0, bi0, ci0, ai1, bi1, ci1;
  logic [31:0] adi0, bdi0, ad0, bd0, adi1, bdi1, ad1, bd1;
  logic [127:0] cd0;
  logic [63:0] cd1;
  logic [31:0] a_mem [0:1023];
  logic [31:0] b_mem [0:1023];
  logic [127:0] c0 [0:15];
  logic [63:0] c1 [0:15];
  int wr0, wr1, total = 0, bad = 0;
  int cyc, dn;
  bit ldn;
  int am [6][3];
  int bm [3][5];

  always #5 clk = ~clk;

  tpu_tiled_array dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .K(K), .M(M), .N(N), .busy(busy0), .done(done0),
    .A_wr_en(awe0), .A_index(ai0), .A_data_in(adi0), .A_data_out(ad0),
    .B_wr_en(bwe0), .B_index(bi0), .B_data_in(bdi0), .B_data_out(bd0),
    .C_wr_en(cwe0), .C_index(ci0), .C_data_in(cd0)
  );

  tpu_tiled_array #(.SIGNED(1'b1), .ACC_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .K(K), .M(M), .N(N), .busy(busy1), .done(done1),
    .A_wr_en(awe1), .A_index(ai1), .A_data_in(adi1), .A_data_out(ad1),
    .B_wr_en(bwe1), .B_index(bi1), .B_data_in(bdi1), .B_data_out(bd1),
    .C_wr_en(cwe1), .C_index(ci1), .C_data_in(cd1)
  );

  always_ff @(posedge clk) begin
    ad0 <= a_mem[ai0[9:0]];
    bd0 <= b_mem[bi0[9:0]];
    ad1 <= a_mem[ai1[9:0]];
    bd1 <= b_mem[bi1[9:0]];
  end

  always @(posedge clk) begin
    if (clr) begin
      wr0 <= 0;
      wr1 <= 0;
      for (int i = 0; i < 16; i++) begin
        c0[i] <= '0;
        c1[i] <= '0;
      end
    end else begin
      if (cwe0) begin
        c0[ci0[3:0]] <= cd0;
        wr0 <= wr0 + 1;
      end
      if (cwe1) begin
        c1[ci1[3:0]] <= cd1;
        wr1 <= wr1 + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_c();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic run(input bit s, input int k, input int m, input int n);
    @(negedge clk);
    K = 8'(k);
    M = 8'(m);
    N = 8'(n);
    if (s) iv1 = 1'b1; else iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    iv1 = 1'b0;
    cyc = 0;
    dn = 0;
    ldn = 1'b0;
    while ((s ? busy1 : busy0) && cyc < 2000) begin
      ldn = s ? done1 : done0;
      dn += int'(ldn);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic load_ident();
    for (int k = 0; k < 4; k++) begin
      a_mem[k] = 32'd2 << (8 * (3 - k));
      b_mem[k] = 32'd2 << (8 * (3 - k));
    end
  endtask

  task automatic check_ident(input string tag);
    check({tag, "_writes"}, 128'(wr0), 128'd4);
    for (int i = 0; i < 4; i++) check($sformatf("%s_row%0d", tag, i), c0[i], 128'd4 << (32 * (3 - i)));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy0), 128'd0);
    check("rst_done", 128'(done0), 128'd0);
    check("rst_cwe", 128'(cwe0), 128'd0);
    check("rst_aidx", 128'(ai0), 128'd0);
    check("rst_cidx", 128'(ci0), 128'd0);
    check("rst_cdata", cd0, 128'd0);
    rst_n = 1'b1;
    clear_c();
    load_ident();
    run(1'b0, 4, 4, 4);
    check("id_busy", 128'(cyc), 128'd17);
    check("id_done_cnt", 128'(dn), 128'd1);
    check("id_done_last", 128'(ldn), 128'd1);
    check_ident("id");
    clear_c();
    run(1'b0, 0, 4, 4);
    check("k0_busy", 128'(cyc), 128'd1);
    check("k0_done", 128'(dn), 128'd1);
    check("k0_writes", 128'(wr0), 128'd0);
    clear_c();
    fork
      run(1'b0, 4, 4, 4);
      begin
        repeat (5) @(negedge clk);
        K = 8'd0;
        iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
      end
    join
    check("ivfeed_busy", 128'(cyc), 128'd17);
    check_ident("ivfeed");
    for (int i = 0; i < 6; i++) for (int k = 0; k < 3; k++) am[i][k] = (i * 37 + k * 53 + 11) & 255;
    for (int k = 0; k < 3; k++) for (int j = 0; j < 5; j++) bm[k][j] = (k * 71 + j * 29 + 200) & 255;
    for (int t = 0; t < 2; t++) for (int k = 0; k < 3; k++) begin
      a_mem[t*3+k] = '0;
      b_mem[t*3+k] = '0;
      for (int e = 0; e < 4; e++) begin
        if (t * 4 + e < 6) a_mem[t*3+k] |= 32'(am[t*4+e][k]) << (8 * (3 - e));
        if (t * 4 + e < 5) b_mem[t*3+k] |= 32'(bm[k][t*4+e]) << (8 * (3 - e));
      end
    end
    clear_c();
    run(1'b0, 3, 6, 5);
    check("tile_busy", 128'(cyc), 128'd61);
    check("tile_writes", 128'(wr0), 128'd12);
    for (int m = 0; m < 6; m++) for (int t = 0; t < 2; t++) begin
      logic [127:0] exp;
      exp = '0;
      for (int c = 0; c < 4; c++) begin
        int v;
        v = 0;
        if (t * 4 + c < 5) for (int k = 0; k < 3; k++) v += am[m][k] * bm[k][t*4+c];
        exp |= 128'(v) << (32 * (3 - c));
      end
      check($sformatf("tile_c%0d_%0d", m, t), c0[m*2+t], exp);
    end
    for (int i = 12; i < 16; i++) check($sformatf("tile_unwritten%0d", i), c0[i], 128'd0);
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = 32'hffff_ffff;
      b_mem[i] = 32'hffff_ffff;
    end
    clear_c();
    @(negedge clk);
    K = 8'd4;
    M = 8'd4;
    N = 8'd4;
    iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy0), 128'd0);
    check("midrst_cwe", 128'(cwe0), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_writes", 128'(wr0), 128'd0);
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    load_ident();
    clear_c();
    run(1'b0, 4, 4, 4);
    check_ident("postrst");
    for (int i = 0; i < 255; i++) begin
      a_mem[i] = 32'hffff_ffff;
      b_mem[i] = 32'hffff_ffff;
    end
    clear_c();
    run(1'b0, 255, 4, 4);
    check("longk_busy", 128'(cyc), 128'd268);
    check("longk_writes", 128'(wr0), 128'd4);
    for (int i = 0; i < 4; i++) check($sformatf("longk_row%0d", i), c0[i], {4{32'd16581375}});
    for (int i = 0; i < 3; i++) begin
      a_mem[i] = 32'h8000_0000;
      b_mem[i] = 32'h8000_0000;
    end
    clear_c();
    run(1'b1, 1, 1, 1);
    check("s_k1_busy", 128'(cyc), 128'd14);
    check("s_k1_writes", 128'(wr1), 128'd1);
    check("s_k1_c", 128'(c1[0]), 128'h4000_0000_0000_0000);
    clear_c();
    run(1'b1, 3, 1, 1);
    check("s_k3_writes", 128'(wr1), 128'd1);
    check("s_k3_c", 128'(c1[0]), 128'hc000_0000_0000_0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
